// File: rtl/sw_pkg.sv
// Stopwatch run-control shared types.
// State encoding and elaboration-time sizing helpers.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  function automatic int unsigned div_of(
    input int unsigned clk_hz,
    input int unsigned tick_hz
  );
    return clk_hz / tick_hz;
  endfunction

  function automatic int unsigned width_of(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Button synchroniser and debouncer.
// Emits a one-cycle press on each accepted 0->1 level.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = width_of(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // accept a new level once it has differed for DEB_CYCLES samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= s2;
        press <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_run_ctrl.sv
// Stopwatch front end: debounced buttons, run FSM,
// 100 Hz tick prescaler and downstream clear pulse.
module sw_run_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic clk_psec,
  output logic clr,
  output logic running
);

  localparam int unsigned DIV = div_of(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = width_of(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  state_t        state;
  logic [PW-1:0] cnt;
  logic          ss_p;
  logic          clr_p;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_ss),
    .press   (ss_p)
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_clr),
    .press   (clr_p)
  );

  // run FSM with prescaler; the leaving-RUN edge neither counts nor ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clk_psec <= 1'b0;
      clr      <= 1'b0;
      running  <= 1'b0;
    end else begin
      clk_psec <= 1'b0;
      clr      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (clr_p) clr <= 1'b1;
          if (ss_p) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ss_p) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (cnt == LAST) begin
            cnt      <= '0;
            clk_psec <= 1'b1;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (clr_p) begin
            state <= ST_IDLE;
            cnt   <= '0;
            clr   <= 1'b1;
          end else if (ss_p) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Self-checking bench for sw_run_ctrl.
// DIV=4, DEB_CYCLES=3; inputs driven and outputs sampled on negedge.
module tb_sw_run_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_ss = 1'b0;
  logic btn_clr = 1'b0;
  logic clk_psec;
  logic clr;
  logic running;

  always #5 clk = ~clk;

  sw_run_ctrl #(
    .CLK_HZ     (8),
    .TICK_HZ    (2),
    .DEB_CYCLES (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_ss   (btn_ss),
    .btn_clr  (btn_clr),
    .clk_psec (clk_psec),
    .clr      (clr),
    .running  (running)
  );

  typedef struct {
    int n;
    bit ss;
    bit cl;
    bit e_psec;
    bit e_clr;
    bit e_run;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input int n, input bit ss, input bit cl,
                     input bit p, input bit c, input bit r);
    vec_t v;
    v.n = n;
    v.ss = ss;
    v.cl = cl;
    v.e_psec = p;
    v.e_clr = c;
    v.e_run = r;
    tbl.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [2:0] exp);
    logic [2:0] act;
    act = {clk_psec, clr, running};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: psec/clr/run got %b expected %b",
               name, act, exp);
    end
  endtask

  // both buttons together for 4 cycles; FSM acts 5 edges later
  task automatic both(input string nm, input bit e_clr,
                      input bit e_run);
    for (int i = 0; i < 12; i++) begin
      btn_ss  = (i < 4);
      btn_clr = (i < 4);
      @(negedge clk);
      if (i == 5) check(nm, {1'b0, e_clr, e_run});
      if (i == 6) check({nm, "_after"}, {1'b0, 1'b0, e_run});
    end
  endtask

  initial begin
    // idle, start, ticks, glitch
    add(20, 0, 0, 0, 0, 0);
    add(5,  1, 0, 0, 0, 0);
    add(4,  1, 0, 0, 0, 1);
    add(1,  1, 0, 1, 0, 1);
    add(3,  0, 0, 0, 0, 1);
    add(1,  0, 0, 1, 0, 1);
    add(3,  0, 0, 0, 0, 1);
    add(1,  0, 0, 1, 0, 1);
    add(2,  1, 0, 0, 0, 1);
    add(1,  0, 0, 0, 0, 1);
    add(1,  0, 0, 1, 0, 1);
    // pause with prescaler at 1
    add(3,  1, 0, 0, 0, 1);
    add(1,  1, 0, 1, 0, 1);
    add(1,  0, 0, 0, 0, 1);
    add(50, 0, 0, 0, 0, 0);
    // resume: tick 3 cycles after running rises
    add(4,  1, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0);
    add(3,  0, 0, 0, 0, 1);
    add(1,  0, 0, 1, 0, 1);
    // pause again, then clear
    add(3,  1, 0, 0, 0, 1);
    add(1,  1, 0, 1, 0, 1);
    add(1,  0, 0, 0, 0, 1);
    add(1,  0, 0, 0, 0, 0);
    add(5,  0, 0, 0, 0, 0);
    add(4,  0, 1, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 1, 0);
    add(5,  0, 0, 0, 0, 0);
    // restart: full 4-cycle first interval
    add(4,  1, 0, 0, 0, 0);
    add(1,  0, 0, 0, 0, 0);
    add(4,  0, 0, 0, 0, 1);
    add(1,  0, 0, 1, 0, 1);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", 3'b000);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        btn_ss  = tbl[i].ss;
        btn_clr = tbl[i].cl;
        @(negedge clk);
        check($sformatf("row%0d.%0d", i, j),
              {tbl[i].e_psec, tbl[i].e_clr, tbl[i].e_run});
      end
    end

    // asynchronous reset while running, between edges
    #3 reset_n = 1'b0;
    #1 check("async_reset", 3'b000);
    @(negedge clk);
    reset_n = 1'b1;

    both("both_idle", 1'b1, 1'b1);
    both("both_run", 1'b0, 1'b0);
    both("both_pause", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
